// File: rtl/bcast_bus_pkg.sv
// Shared definitions for the broadcast bus pipeline: counter width,
// default lane geometry, the default-width stage record and a clog2 helper.
package bcast_bus_pkg;

    localparam int CNT_WIDTH      = 16;
    localparam int DEF_N_SRC      = 16;
    localparam int DEF_N_DST      = 16;
    localparam int DEF_DATA_WIDTH = 16;

    // One pipeline slot at the default geometry. Instances with other widths
    // declare the same record shape locally from their own parameters.
    typedef struct packed {
        logic                      valid;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      coll;
        logic [DEF_N_DST-1:0]      dst_en;
    } bcast_stage_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcast_prio_sel.sv
// Fixed-priority source selector: lowest requesting lane wins, and a
// collision flag is raised when more than one lane requests at once.
// Purely combinational; lane count comes from N_SRC.
module bcast_prio_sel
    import bcast_bus_pkg::*;
#(
    parameter int N_SRC      = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic [N_SRC-1:0]            valid_in,
    input  logic [N_SRC*DATA_WIDTH-1:0] data_in,
    output logic                        sel_valid,
    output logic [DATA_WIDTH-1:0]       sel_data,
    output logic                        coll
);

    localparam int POP_W = clog2(N_SRC + 1);

    // seen[i] is set when some lane below i is requesting; pick[i] carries
    // the word chosen among lanes below i. Unpacked so each link is its own net.
    logic                  seen [N_SRC+1];
    logic [DATA_WIDTH-1:0] pick [N_SRC+1];
    logic [POP_W-1:0]      pop;

    assign seen[0] = 1'b0;
    assign pick[0] = '0;

    for (genvar i = 0; i < N_SRC; i++) begin : g_lane
        assign seen[i+1] = seen[i] | valid_in[i];
        assign pick[i+1] = (valid_in[i] && !seen[i])
                         ? data_in[i*DATA_WIDTH +: DATA_WIDTH]
                         : pick[i];
    end

    assign sel_valid = seen[N_SRC];
    assign sel_data  = pick[N_SRC];

    // Count requesting lanes; two or more means a collision.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_SRC; i++) begin
            pop = pop + POP_W'(valid_in[i]);
        end
    end

    assign coll = (pop > POP_W'(1));

endmodule

// File: rtl/bcast_bus_pipe.sv
// Parametrised row/column broadcast bus: picks one source word by fixed
// priority and fans it out to N_DST destinations through PIPELINE_DEPTH
// register stages, with per-destination enables, global stall and
// collision reporting.
// Optional: define BCAST_BUS_COLLISION_CNT_EN to add a saturating
// collision_cnt output.
module bcast_bus_pipe
    import bcast_bus_pkg::*;
#(
    parameter int N_SRC          = DEF_N_SRC,
    parameter int N_DST          = DEF_N_DST,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int PIPELINE_DEPTH = 1,
    parameter int HOLD_LAST      = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_SRC-1:0]            valid_in,
    input  logic [N_SRC*DATA_WIDTH-1:0] data_in,
    input  logic [N_DST-1:0]            dst_en,
    input  logic                        stall,
    output logic [N_DST-1:0]            valid_out,
    output logic [N_DST*DATA_WIDTH-1:0] data_out,
    output logic                        collision
`ifdef BCAST_BUS_COLLISION_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]        collision_cnt
`endif
);

    if (PIPELINE_DEPTH < 1) begin : g_bad_depth
        $error("bcast_bus_pipe: PIPELINE_DEPTH must be at least 1");
    end

    // Same record shape as the package default, sized by this instance.
    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic                  coll;
        logic [N_DST-1:0]      dst_en;
    } stage_t;

    logic                        sel_valid;
    logic [DATA_WIDTH-1:0]       sel_data;
    logic                        sel_coll;

    stage_t                      stage_q [PIPELINE_DEPTH];
    stage_t                      stage_d [PIPELINE_DEPTH];
    stage_t                      out_stage;
    stage_t                      out_next;

    logic [N_DST*DATA_WIDTH-1:0] data_q;
    logic [N_DST*DATA_WIDTH-1:0] data_d;

    bcast_prio_sel #(
        .N_SRC      (N_SRC),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sel (
        .valid_in  (valid_in),
        .data_in   (data_in),
        .sel_valid (sel_valid),
        .sel_data  (sel_data),
        .coll      (sel_coll)
    );

    // Stage 0 takes the freshly selected word; every later stage takes its predecessor.
    always_comb begin
        stage_d[0].valid  = sel_valid;
        stage_d[0].data   = sel_data;
        stage_d[0].coll   = sel_coll;
        stage_d[0].dst_en = dst_en;
        for (int k = 1; k < PIPELINE_DEPTH; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Pipeline registers advance together and freeze together on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPELINE_DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < PIPELINE_DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_stage = stage_q[PIPELINE_DEPTH-1];
    assign out_next  = stage_d[PIPELINE_DEPTH-1];

    // Per-lane data register tracks the word entering the output stage, so
    // idle lanes can either clear or keep their last word.
    always_comb begin
        data_d = data_q;
        for (int j = 0; j < N_DST; j++) begin
            if (out_next.valid && out_next.dst_en[j]) begin
                data_d[j*DATA_WIDTH +: DATA_WIDTH] = out_next.data;
            end else if (HOLD_LAST == 0) begin
                data_d[j*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    // Output data lanes share the pipeline's load enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (!stall) begin
            data_q <= data_d;
        end
    end

    assign valid_out = {N_DST{out_stage.valid}} & out_stage.dst_en;
    assign data_out  = data_q;
    assign collision = out_stage.valid & out_stage.coll;

`ifdef BCAST_BUS_COLLISION_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Count collisions leaving the output stage, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!stall && collision && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign collision_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_bcast_bus_pipe.sv
// Directed bench for bcast_bus_pipe with N_SRC=4, N_DST=5, DATA_WIDTH=16,
// PIPELINE_DEPTH=2. A second instance runs with HOLD_LAST=1 on the same
// inputs. Counter checks are active when BCAST_BUS_COLLISION_CNT_EN is defined.
module tb_bcast_bus_pipe;

    localparam int N_SRC = 4;
    localparam int N_DST = 5;
    localparam int DW    = 16;
    localparam int DEPTH = 2;

    logic                 clk;
    logic                 rst_n;
    logic [N_SRC-1:0]     valid_in;
    logic [N_SRC*DW-1:0]  data_in;
    logic [N_DST-1:0]     dst_en;
    logic                 stall;

    logic [N_DST-1:0]     valid_out;
    logic [N_DST*DW-1:0]  data_out;
    logic                 collision;
    logic [N_DST-1:0]     h_valid_out;
    logic [N_DST*DW-1:0]  h_data_out;
    logic                 h_collision;
`ifdef BCAST_BUS_COLLISION_CNT_EN
    logic [15:0]          collision_cnt;
    logic [15:0]          h_collision_cnt;
`endif

    int errors = 0;
    int checks = 0;

    bcast_bus_pipe #(
        .N_SRC(N_SRC), .N_DST(N_DST), .DATA_WIDTH(DW),
        .PIPELINE_DEPTH(DEPTH), .HOLD_LAST(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .dst_en(dst_en), .stall(stall), .valid_out(valid_out),
        .data_out(data_out), .collision(collision)
`ifdef BCAST_BUS_COLLISION_CNT_EN
        , .collision_cnt(collision_cnt)
`endif
    );

    bcast_bus_pipe #(
        .N_SRC(N_SRC), .N_DST(N_DST), .DATA_WIDTH(DW),
        .PIPELINE_DEPTH(DEPTH), .HOLD_LAST(1)
    ) dut_hold (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
        .dst_en(dst_en), .stall(stall), .valid_out(h_valid_out),
        .data_out(h_data_out), .collision(h_collision)
`ifdef BCAST_BUS_COLLISION_CNT_EN
        , .collision_cnt(h_collision_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_in = '0;
        data_in  = '0;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        stall  = 1'b0;
        dst_en = '0;
        clear_inputs();
        #12;
        if (valid_out !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b expected %b", valid_out, 5'b0);
        end
        checks++;
        if (data_out !== 80'h0) begin
            errors++; $display("[TB] FAIL reset_data: got %h expected 0", data_out);
        end
        checks++;
        if (collision !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_collision: got %b expected 0", collision);
        end
        checks++;
`ifdef BCAST_BUS_COLLISION_CNT_EN
        if (collision_cnt !== 16'h0) begin
            errors++; $display("[TB] FAIL reset_cnt: got %h expected 0", collision_cnt);
        end
        checks++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_source();
        valid_in = 4'b0100;
        data_in[2*DW +: DW] = 16'hBEEF;
        dst_en = 5'b11111;
        step();
        clear_inputs();
        step();
        if (valid_out !== 5'b11111) begin
            errors++; $display("[TB] FAIL single_valid: got %b expected %b", valid_out, 5'b11111);
        end
        checks++;
        if (data_out !== {5{16'hBEEF}}) begin
            errors++; $display("[TB] FAIL single_data: got %h expected %h", data_out, {5{16'hBEEF}});
        end
        checks++;
        if (collision !== 1'b0) begin
            errors++; $display("[TB] FAIL single_collision: got %b expected 0", collision);
        end
        checks++;
        step();
        if (valid_out !== 5'b0 || data_out !== 80'h0 || collision !== 1'b0) begin
            errors++; $display("[TB] FAIL single_drain: got valid=%b data=%h coll=%b expected all zero",
                               valid_out, data_out, collision);
        end
        checks++;
        if (h_valid_out !== 5'b0 || h_data_out !== {5{16'hBEEF}}) begin
            errors++; $display("[TB] FAIL single_hold: got valid=%b data=%h expected valid=0 data=%h",
                               h_valid_out, h_data_out, {5{16'hBEEF}});
        end
        checks++;
    endtask

    task automatic test_priority_collision();
        valid_in = 4'b1010;
        data_in[1*DW +: DW] = 16'h0011;
        data_in[3*DW +: DW] = 16'h2200;
        dst_en = 5'b11111;
        step();
        clear_inputs();
        step();
        if (data_out !== {5{16'h0011}}) begin
            errors++; $display("[TB] FAIL prio_data: got %h expected %h", data_out, {5{16'h0011}});
        end
        checks++;
        if (collision !== 1'b1) begin
            errors++; $display("[TB] FAIL prio_collision: got %b expected 1", collision);
        end
        checks++;
`ifdef BCAST_BUS_COLLISION_CNT_EN
        if (collision_cnt !== 16'd0) begin
            errors++; $display("[TB] FAIL prio_cnt_before: got %0d expected 0", collision_cnt);
        end
        checks++;
`endif
        step();
        if (collision !== 1'b0) begin
            errors++; $display("[TB] FAIL prio_collision_clear: got %b expected 0", collision);
        end
        checks++;
`ifdef BCAST_BUS_COLLISION_CNT_EN
        if (collision_cnt !== 16'd1) begin
            errors++; $display("[TB] FAIL prio_cnt_after: got %0d expected 1", collision_cnt);
        end
        checks++;
`endif
    endtask

    task automatic test_mask();
        valid_in = 4'b0001;
        data_in[0 +: DW] = 16'h1234;
        dst_en = 5'b00101;
        step();
        clear_inputs();
        dst_en = 5'b11111;
        step();
        if (valid_out !== 5'b00101) begin
            errors++; $display("[TB] FAIL mask_valid: got %b expected %b", valid_out, 5'b00101);
        end
        checks++;
        if (data_out !== {16'h0, 16'h0, 16'h1234, 16'h0, 16'h1234}) begin
            errors++; $display("[TB] FAIL mask_data: got %h expected %h", data_out,
                               {16'h0, 16'h0, 16'h1234, 16'h0, 16'h1234});
        end
        checks++;
        if (h_data_out !== {16'h0011, 16'h0011, 16'h1234, 16'h0011, 16'h1234}) begin
            errors++; $display("[TB] FAIL mask_hold_data: got %h expected %h", h_data_out,
                               {16'h0011, 16'h0011, 16'h1234, 16'h0011, 16'h1234});
        end
        checks++;
        step();
    endtask

    task automatic test_back_to_back_stall();
        dst_en = 5'b11111;
        valid_in = 4'b0001;
        data_in[0 +: DW] = 16'h0001;
        step();
        data_in[0 +: DW] = 16'h0002;
        step();
        if (valid_out !== 5'b11111 || data_out !== {5{16'h0001}}) begin
            errors++; $display("[TB] FAIL stall_first_A: got valid=%b data=%h expected valid=11111 data=%h",
                               valid_out, data_out, {5{16'h0001}});
        end
        checks++;
        stall = 1'b1;
        data_in[0 +: DW] = 16'h00FF;
        for (int c = 0; c < 3; c++) begin
            step();
            if (valid_out !== 5'b11111 || data_out !== {5{16'h0001}}) begin
                errors++; $display("[TB] FAIL stall_hold_A cycle %0d: got valid=%b data=%h expected valid=11111 data=%h",
                                   c, valid_out, data_out, {5{16'h0001}});
            end
            checks++;
        end
        stall = 1'b0;
        clear_inputs();
        step();
        if (valid_out !== 5'b11111 || data_out !== {5{16'h0002}}) begin
            errors++; $display("[TB] FAIL stall_then_B: got valid=%b data=%h expected valid=11111 data=%h",
                               valid_out, data_out, {5{16'h0002}});
        end
        checks++;
        step();
        if (valid_out !== 5'b0 || data_out !== 80'h0) begin
            errors++; $display("[TB] FAIL stall_no_extra: got valid=%b data=%h expected zero",
                               valid_out, data_out);
        end
        checks++;
    endtask

    task automatic test_hold_last();
        dst_en = 5'b11111;
        valid_in = 4'b0001;
        data_in[0 +: DW] = 16'h00AA;
        step();
        clear_inputs();
        step();
        if (h_valid_out !== 5'b11111 || h_data_out !== {5{16'h00AA}}) begin
            errors++; $display("[TB] FAIL hold_word: got valid=%b data=%h expected valid=11111 data=%h",
                               h_valid_out, h_data_out, {5{16'h00AA}});
        end
        checks++;
        step();
        step();
        if (h_valid_out !== 5'b0 || h_data_out !== {5{16'h00AA}}) begin
            errors++; $display("[TB] FAIL hold_idle: got valid=%b data=%h expected valid=0 data=%h",
                               h_valid_out, h_data_out, {5{16'h00AA}});
        end
        checks++;
        if (data_out !== 80'h0) begin
            errors++; $display("[TB] FAIL hold_zero_mode: got %h expected 0", data_out);
        end
        checks++;
    endtask

    task automatic test_async_reset();
        dst_en = 5'b11111;
        valid_in = 4'b0001;
        data_in[0 +: DW] = 16'h0101;
        step();
        data_in[0 +: DW] = 16'h0202;
        step();
        if (valid_out !== 5'b11111 || data_out !== {5{16'h0101}}) begin
            errors++; $display("[TB] FAIL areset_inflight: got valid=%b data=%h expected valid=11111 data=%h",
                               valid_out, data_out, {5{16'h0101}});
        end
        checks++;
        #2;
        rst_n = 1'b0;
        #1;
        if (valid_out !== 5'b0 || data_out !== 80'h0 || h_data_out !== 80'h0 || collision !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_immediate: got valid=%b data=%h hold_data=%h coll=%b expected zero",
                               valid_out, data_out, h_data_out, collision);
        end
        checks++;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (valid_out !== 5'b0 || data_out !== 80'h0 || h_valid_out !== 5'b0 || h_data_out !== 80'h0) begin
                errors++; $display("[TB] FAIL areset_stale cycle %0d: got valid=%b data=%h hold_valid=%b hold_data=%h expected zero",
                                   c, valid_out, data_out, h_valid_out, h_data_out);
            end
            checks++;
        end
`ifdef BCAST_BUS_COLLISION_CNT_EN
        if (collision_cnt !== 16'd0) begin
            errors++; $display("[TB] FAIL areset_cnt: got %0d expected 0", collision_cnt);
        end
        checks++;
`endif
    endtask

`ifdef BCAST_BUS_COLLISION_CNT_EN
    task automatic test_cnt_saturation();
        valid_in = 4'b0011;
        data_in[0 +: DW] = 16'h0005;
        data_in[1 +: DW] = 16'h0006;
        dst_en = 5'b00000;
        repeat (65540) step();
        if (collision_cnt !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL cnt_saturate: got %h expected FFFF", collision_cnt);
        end
        checks++;
        repeat (3) step();
        if (h_collision_cnt !== 16'hFFFF) begin
            errors++; $display("[TB] FAIL cnt_stick: got %h expected FFFF", h_collision_cnt);
        end
        checks++;
        clear_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_single_source();
        test_priority_collision();
        test_mask();
        test_back_to_back_stall();
        test_hold_last();
        test_async_reset();
`ifdef BCAST_BUS_COLLISION_CNT_EN
        test_cnt_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcast_bus_pipe.md
Name: bcast_bus_pipe

Overview:
- Parametrised successor to the fixed-16 row/column broadcast buses feeding the systolic MMU array.
- Selects one word from N_SRC requesting sources by fixed priority, with lowest index winning.
- Broadcasts that word to N_DST destinations through a configurable register pipeline.
- Adds a per-destination enable mask, stall, collision detection and an optional idle-hold mode.

Parameters:
- N_SRC, 16, number of source lanes (>=1).
- N_DST, 16, number of destination lanes (>=1; col bus instances use ARRAY_SIZE+1).
- DATA_WIDTH, 16, word width.
- PIPELINE_DEPTH, 1, register stages from input to output (>=1; a value of 0 is an elaboration error).
- HOLD_LAST, 0, idle data_out behaviour: 0 drives zero, 1 holds the last broadcast word.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- valid_in  in  N_SRC  per-source request
- data_in  in  N_SRC*DATA_WIDTH  source words, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- dst_en  in  N_DST  destination enable mask, sampled with the data
- stall  in  1  freeze the whole pipeline
- valid_out  out  N_DST  per-destination valid
- data_out  out  N_DST*DATA_WIDTH  per-destination word
- collision  out  1  more than one source requested the word now at the output

Behaviour:
- Reset (async, rst_n=0): all stage registers, valid_out, data_out and collision go to 0 immediately. The optional counter also goes to 0. Reset mid-stream discards all in-flight words.
- Selection (combinational):
  - sel_valid = |valid_in.
  - sel_data = data_in lane of the lowest set index of valid_in; 0 if none.
  - coll = popcount(valid_in) > 1.
  - Unlike the OR-merge bus, data is never OR-corrupted.
- Capture: when stall=0, stage 1 loads {sel_valid, sel_data, coll, dst_en}. When stall=1, inputs in that cycle are not captured; sources must hold.
- Pipeline: stage k loads stage k-1 on every stall=0 cycle. The final stage is the output register.
- Latency: a request at edge t appears at the outputs after PIPELINE_DEPTH non-stalled edges. Throughput is one word per non-stalled cycle.
- Output (final stage S, per destination j):
  - valid_out[j] = S.valid & S.dst_en[j].
  - data_out[j] = S.data when valid_out[j].
  - Otherwise data_out[j] = 0 if HOLD_LAST=0. If HOLD_LAST=1 it keeps the previous value of that lane.
- collision = S.valid & S.coll.
- Stall: every register, outputs included, holds its value. valid_out stays asserted if it was asserted; consumers must qualify with their own stall view.
- Simultaneous stall and reset: reset wins.
- dst_en=0 with sel_valid=1: the word still occupies its pipeline slot; all valid_out are 0.
- Zero-valid cycle: a bubble propagates. Outputs are 0, or held when HOLD_LAST=1.

Optional Feature:
- Macro: BCAST_BUS_COLLISION_CNT_EN.
- Defined:
  - Adds output port collision_cnt, width CNT_WIDTH.
  - Saturating counter, +1 on each output-stage cycle where collision=1 and stall=0.
  - Sticks at all-ones; cleared only by rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package bcast_bus_pkg:
  - CNT_WIDTH=16.
  - Stage record typedef {valid, data, coll, dst_en}, parameterised via localparam widths.
  - clog2 helper.
- Sub-module bcast_prio_sel, combinational:
  - Takes valid_in and data_in.
  - Produces sel_valid, sel_data and coll.
  - Built as a generate loop, with no fixed lane count.

Test Plan (N_SRC=4, N_DST=5, DATA_WIDTH=16, PIPELINE_DEPTH=2, HOLD_LAST=0):
- Single source: valid_in=0100, lane2=0xBEEF, dst_en=11111 at edge 0 → edge 2: valid_out=11111, all data_out lanes=0xBEEF, collision=0. Edge 3: all 0.
- Priority and collision: valid_in=1010, lane1=0x0011, lane3=0x2200 → outputs 0x0011 on all lanes (not 0x2211), collision=1. With the macro defined, collision_cnt=1.
- Mask: dst_en=00101, single valid word 0x1234 → valid_out=00101; lanes 0 and 2 = 0x1234, others 0.
- Stall: back-to-back words A=0x0001 and B=0x0002; stall=1 for 3 cycles right after B is captured → output holds A for 3 extra cycles, B follows one non-stalled edge later, nothing is lost or duplicated.
- HOLD_LAST=1 rerun: word 0x00AA, then idle → data_out stays 0x00AA and valid_out=0.
- Async reset mid-stream: rst_n low between edges while two words are in flight → outputs 0 immediately; no stale word emerges after release. Counter saturation: force 65537 collisions → collision_cnt=0xFFFF.
